// File: rtl/camera_pkg.sv
// Shared camera pipeline definitions: frame gate state encoding and default widths.
// Imported by the capture frame gate, its pixel bus interface and its statistics block.
package camera_pkg;

    localparam int PIXEL_WIDTH_DEFAULT = 10;
    localparam int COUNT_WIDTH_DEFAULT = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        WAIT_SOF = 2'd2,
        PASS     = 2'd3
    } frame_gate_state_t;

endpackage

// File: rtl/capture_frame_gate_if.sv
// Pixel bus: one Bayer sample qualified by line valid and frame valid.
// The producer uses the master modport and the consumer uses the slave modport.
interface capture_frame_gate_if
    import camera_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT
);

    logic [PIXEL_WIDTH-1:0] bayer_data;
    logic                   line_valid;
    logic                   frame_valid;

    modport master (
        output bayer_data,
        output line_valid,
        output frame_valid
    );

    modport slave (
        input bayer_data,
        input line_valid,
        input frame_valid
    );

endinterface

// File: rtl/frame_gate_stats.sv
// Per-frame geometry statistics for the capture frame gate: first-line width,
// saturating line count and a sticky line-length mismatch flag (FRAME_GATE_STATS_EN builds only).
module frame_gate_stats
    import camera_pkg::*;
#(
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clear_i,
    input  logic                   pixel_i,
    input  logic                   in_pass_i,
    output logic [COUNT_WIDTH-1:0] line_width_o,
    output logic [COUNT_WIDTH-1:0] line_count_o,
    output logic                   mismatch_o
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [COUNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [COUNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
    logic [COUNT_WIDTH-1:0] width_q, width_d;
    logic                   mismatch_q, mismatch_d;
    logic                   first_seen_q, first_seen_d;
    logic                   in_line_q;
    logic                   line_end;

    // A line closes on the first non-pixel cycle after a pixel, which also
    // catches a line cut short by frame valid dropping underneath it.
    assign line_end = in_pass_i && in_line_q && !pixel_i;

    always_comb begin
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        width_d      = width_q;
        mismatch_d   = mismatch_q;
        first_seen_d = first_seen_q;
        if (clear_i) begin
            pix_cnt_d    = pixel_i ? COUNT_WIDTH'(1) : '0;
            line_cnt_d   = '0;
            width_d      = '0;
            mismatch_d   = 1'b0;
            first_seen_d = 1'b0;
        end else begin
            if (pixel_i) begin
                if (pix_cnt_q == CNT_MAX) begin
                    mismatch_d = 1'b1;
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
            if (line_end) begin
                pix_cnt_d = '0;
                if (line_cnt_q != CNT_MAX) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
                if (!first_seen_q) begin
                    width_d      = pix_cnt_q;
                    first_seen_d = 1'b1;
                end else if (pix_cnt_q != width_q) begin
                    mismatch_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            width_q      <= '0;
            mismatch_q   <= 1'b0;
            first_seen_q <= 1'b0;
            in_line_q    <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            width_q      <= width_d;
            mismatch_q   <= mismatch_d;
            first_seen_q <= first_seen_d;
            in_line_q    <= pixel_i;
        end
    end

    assign line_width_o = width_q;
    assign line_count_o = line_cnt_q;
    assign mismatch_o   = mismatch_q;

endmodule

// File: rtl/capture_frame_gate.sv
// Capture frame gate: arms on a start request and forwards exactly one whole Bayer frame.
// Define FRAME_GATE_STATS_EN to build the per-frame width/count/mismatch statistics.
module capture_frame_gate
    import camera_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEFAULT,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   start_capture_in,
    capture_frame_gate_if.slave    pix_in,
    capture_frame_gate_if.master   pix_out,
    output logic                   busy_out,
    output logic                   frame_done_out,
    output logic [COUNT_WIDTH-1:0] line_width_out,
    output logic [COUNT_WIDTH-1:0] line_count_out,
    output logic                   mismatch_out
);

    frame_gate_state_t state_q, state_d;

    logic                   start_q;
    logic                   fv_in_q;
    logic                   done_q, done_d;
    logic [PIXEL_WIDTH-1:0] data_q, data_d;
    logic                   lv_out_q, lv_out_d;
    logic                   fv_out_q, fv_out_d;
    logic                   start_edge;
    logic                   sof;
    logic                   eof;
    logic                   forward;

    assign start_edge = start_capture_in & ~start_q;
    assign sof        = pix_in.frame_valid & ~fv_in_q;
    assign eof        = ~pix_in.frame_valid & fv_in_q;

    // The done cycle still reports busy, so a start edge landing there is ignored.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge && !done_q) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!pix_in.frame_valid) begin
                    state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: begin
                if (sof) begin
                    state_d = PASS;
                end
            end
            PASS: begin
                if (eof) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gating on the next state lets the start-of-frame sample through with one cycle of latency.
    assign forward  = (state_d == PASS);
    assign data_d   = forward ? pix_in.bayer_data : '0;
    assign lv_out_d = forward & pix_in.line_valid;
    assign fv_out_d = forward & pix_in.frame_valid;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            fv_in_q  <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            lv_out_q <= 1'b0;
            fv_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_capture_in;
            fv_in_q  <= pix_in.frame_valid;
            done_q   <= done_d;
            data_q   <= data_d;
            lv_out_q <= lv_out_d;
            fv_out_q <= fv_out_d;
        end
    end

    assign pix_out.bayer_data  = data_q;
    assign pix_out.line_valid  = lv_out_q;
    assign pix_out.frame_valid = fv_out_q;
    assign frame_done_out      = done_q;
    assign busy_out            = (state_q != IDLE) | done_q;

`ifdef FRAME_GATE_STATS_EN
    logic stats_clear;
    logic stats_pixel;
    logic stats_in_pass;

    assign stats_clear   = (state_q != PASS) && (state_d == PASS);
    assign stats_pixel   = forward && pix_in.line_valid && pix_in.frame_valid;
    assign stats_in_pass = (state_q == PASS);

    frame_gate_stats #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_stats (
        .clk_i        (clock_in),
        .rst_n_i      (reset_n_in),
        .clear_i      (stats_clear),
        .pixel_i      (stats_pixel),
        .in_pass_i    (stats_in_pass),
        .line_width_o (line_width_out),
        .line_count_o (line_count_out),
        .mismatch_o   (mismatch_out)
    );
`else
    assign line_width_out = '0;
    assign line_count_out = '0;
    assign mismatch_out   = 1'b0;
`endif

endmodule

// File: tb/tb_capture_frame_gate.sv
// Self-checking bench for capture_frame_gate: per-cycle traces are built up front and the
// expected outputs are derived from frame-level rules (which frame gets captured, line runs).
module tb_capture_frame_gate;

    localparam int PW = 10;
    localparam int CW = 11;
`ifdef FRAME_GATE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start_capture;
    logic          busy;
    logic          done;
    logic [CW-1:0] lwidth;
    logic [CW-1:0] lcount;
    logic          mism;

    capture_frame_gate_if #(.PIXEL_WIDTH(PW)) in_bus ();
    capture_frame_gate_if #(.PIXEL_WIDTH(PW)) out_bus ();

    capture_frame_gate #(
        .PIXEL_WIDTH (PW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clock_in         (clock),
        .reset_n_in       (reset_n),
        .start_capture_in (start_capture),
        .pix_in           (in_bus),
        .pix_out          (out_bus),
        .busy_out         (busy),
        .frame_done_out   (done),
        .line_width_out   (lwidth),
        .line_count_out   (lcount),
        .mismatch_out     (mism)
    );

    always #5 clock = ~clock;

    int n_checks  = 0;
    int n_fail    = 0;
    int cur       = 0;
    int done_seen = 0;
    bit cmp_en    = 1'b0;

    // stimulus trace, one entry per clock cycle
    bit            tr_st[$];
    bit            tr_fv[$];
    bit            tr_lv[$];
    logic [PW-1:0] tr_dat[$];
    int            line_starts[$];

    // expected outputs per trace cycle
    bit            exp_fv[];
    bit            exp_lv[];
    bit            exp_done[];
    bit            exp_busy[];
    bit            exp_schk[];
    bit            exp_m[];
    logic [PW-1:0] exp_dat[];
    int            exp_w[];
    int            exp_n[];

    int held_w = 0;
    int held_n = 0;
    bit held_m = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s cycle=%0d actual=%0d required=%0d", name, cur, act, req);
        end
    endtask

    task automatic clear_trace();
        tr_st.delete();
        tr_fv.delete();
        tr_lv.delete();
        tr_dat.delete();
    endtask

    task automatic push_cyc(input bit st, input bit fv, input bit lv);
        tr_st.push_back(st);
        tr_fv.push_back(fv);
        tr_lv.push_back(lv);
        tr_dat.push_back(PW'($urandom));
    endtask

    task automatic add_idle(input int n, input bit st);
        for (int i = 0; i < n; i++) push_cyc(st, 1'b0, 1'b0);
    endtask

    // Frame: 2 cycles of front porch, lines separated by 3 blank cycles.
    // trunc_w > 0 cuts the last line to trunc_w pixels with frame valid falling under it.
    task automatic add_frame(input int nlines, input int width, input int rag_line,
                             input int rag_width, input int trunc_w);
        int wl;
        line_starts.delete();
        push_cyc(1'b0, 1'b1, 1'b0);
        push_cyc(1'b0, 1'b1, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            wl = (l == rag_line) ? rag_width : width;
            line_starts.push_back(tr_fv.size());
            if (l == nlines - 1 && trunc_w > 0) begin
                for (int p = 0; p < trunc_w; p++) push_cyc(1'b0, 1'b1, 1'b1);
                push_cyc(1'b0, 1'b0, 1'b1);
            end else begin
                for (int p = 0; p < wl; p++) push_cyc(1'b0, 1'b1, 1'b1);
                for (int p = 0; p < 3; p++) push_cyc(1'b0, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic set_start(input int idx, input int len);
        for (int k = 0; k < len; k++) tr_st[idx + k] = 1'b1;
    endtask

    // Frame-level reference: an accepted request at cycle s (not inside a busy window)
    // captures the first frame whose rise r satisfies r >= s+2 (a blank cycle seen after arming).
    // That frame's inputs r..f-1 appear one cycle later; done pulses at f+1; busy spans s+1..f+1.
    task automatic compute_model();
        int n, busy_end, r, f, w, cnt, run;
        bit mm;
        n = tr_fv.size();
        exp_fv = new[n]; exp_lv = new[n]; exp_done = new[n]; exp_busy = new[n];
        exp_schk = new[n]; exp_m = new[n]; exp_dat = new[n]; exp_w = new[n]; exp_n = new[n];
        for (int c = 0; c < n; c++) begin
            exp_fv[c] = 0; exp_lv[c] = 0; exp_done[c] = 0; exp_busy[c] = 0;
            exp_dat[c] = '0; exp_schk[c] = 1;
            exp_w[c] = held_w; exp_n[c] = held_n; exp_m[c] = held_m;
        end
        busy_end = -1;
        for (int s = 0; s < n; s++) begin
            if (tr_st[s] && (s == 0 || !tr_st[s-1]) && s > busy_end) begin
                r = s + 2;
                while (r < n && !(tr_fv[r] && !tr_fv[r-1])) r++;
                if (r >= n) begin
                    for (int c = s + 1; c < n; c++) exp_busy[c] = 1;
                    busy_end = n;
                end else begin
                    f = r + 1;
                    while (f < n && tr_fv[f]) f++;
                    for (int c = r; c < f && c + 1 < n; c++) begin
                        exp_fv[c+1]  = 1;
                        exp_lv[c+1]  = tr_lv[c];
                        exp_dat[c+1] = tr_dat[c];
                    end
                    if (f + 1 < n) exp_done[f+1] = 1;
                    for (int c = s + 1; c <= f + 1 && c < n; c++) exp_busy[c] = 1;
                    w = 0; cnt = 0; run = 0; mm = 0;
                    for (int c = r; c <= f; c++) begin
                        if (c < f && tr_lv[c]) begin
                            run++;
                        end else if (run > 0) begin
                            cnt++;
                            if (cnt == 1) w = run;
                            else if (run != w) mm = 1;
                            run = 0;
                        end
                    end
                    if (!STATS) begin
                        w = 0; cnt = 0; mm = 0;
                    end
                    for (int c = r + 1; c <= f && c < n; c++) exp_schk[c] = 0;
                    for (int c = f + 1; c < n; c++) begin
                        exp_w[c] = w; exp_n[c] = cnt; exp_m[c] = mm;
                    end
                    held_w = w; held_n = cnt; held_m = mm;
                    busy_end = f + 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int upto, input bit chk);
        for (int c = 0; c < upto; c++) begin
            cur    = c;
            cmp_en = chk;
            start_capture      = tr_st[c];
            in_bus.frame_valid = tr_fv[c];
            in_bus.line_valid  = tr_lv[c];
            in_bus.bayer_data  = tr_dat[c];
            @(posedge clock);
            #1;
        end
        cmp_en = 1'b0;
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("frame_valid_out", out_bus.frame_valid, exp_fv[cur]);
            check("line_valid_out", out_bus.line_valid, exp_lv[cur]);
            check("bayer_data_out", out_bus.bayer_data, exp_dat[cur]);
            check("frame_done_out", done, exp_done[cur]);
            check("busy_out", busy, exp_busy[cur]);
            if (exp_schk[cur]) begin
                check("line_width_out", lwidth, exp_w[cur]);
                check("line_count_out", lcount, exp_n[cur]);
                check("mismatch_out", mism, exp_m[cur]);
            end
            if (done) done_seen++;
        end
    end

    task automatic checkOutput(input string tag);
        check({tag, "_fv"}, out_bus.frame_valid, 0);
        check({tag, "_lv"}, out_bus.line_valid, 0);
        check({tag, "_data"}, out_bus.bayer_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_width"}, lwidth, 0);
        check({tag, "_count"}, lcount, 0);
        check({tag, "_mismatch"}, mism, 0);
    endtask

    initial begin : main
        int d0, idx, nfr, lines, wid, rag, tr, span, stop;
        reset_n            = 1'b0;
        start_capture      = 1'b0;
        in_bus.frame_valid = 1'b0;
        in_bus.line_valid  = 1'b0;
        in_bus.bayer_data  = '0;
        #3;
        checkOutput("reset");
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // clean 16x12 capture, request during blanking
        $display("[TB] clean capture");
        clear_trace();
        add_idle(3, 0); add_idle(3, 1); add_idle(4, 0);
        add_frame(12, 16, -1, 0, 0);
        add_idle(4, 0);
        d0 = done_seen;
        compute_model();
        applyStimulus(tr_fv.size(), 1);
        check("clean_done_count", done_seen - d0, 1);
        check("clean_width", lwidth, STATS ? 16 : 0);
        check("clean_count", lcount, STATS ? 12 : 0);
        check("clean_mismatch", mism, 0);

        // arm at line 5 of frame A; B captured. Then a request coinciding with C's rise captures D.
        $display("[TB] mid-frame arm");
        clear_trace();
        add_idle(4, 0);
        add_frame(8, 6, -1, 0, 0);
        set_start(line_starts[4], 2);
        add_idle(5, 0);
        add_frame(10, 5, -1, 0, 0);
        add_idle(5, 0);
        idx = tr_fv.size();
        add_frame(2, 7, -1, 0, 0);
        set_start(idx, 2);
        add_idle(5, 0);
        add_frame(3, 4, -1, 0, 0);
        add_idle(4, 0);
        d0 = done_seen;
        compute_model();
        applyStimulus(tr_fv.size(), 1);
        check("midarm_done_count", done_seen - d0, 2);
        check("midarm_count", lcount, STATS ? 3 : 0);
        check("midarm_width", lwidth, STATS ? 4 : 0);

        // ragged frame: line 7 of 15 pixels
        $display("[TB] ragged frame");
        clear_trace();
        add_idle(2, 0); add_idle(2, 1); add_idle(3, 0);
        add_frame(12, 16, 6, 15, 0);
        add_idle(4, 0);
        compute_model();
        applyStimulus(tr_fv.size(), 1);
        check("ragged_width", lwidth, STATS ? 16 : 0);
        check("ragged_mismatch", mism, STATS ? 1 : 0);

        // second request during PASS is ignored
        $display("[TB] ignored request");
        clear_trace();
        add_idle(2, 0); add_idle(2, 1); add_idle(3, 0);
        add_frame(6, 5, -1, 0, 0);
        set_start(line_starts[3], 2);
        add_idle(5, 0);
        add_frame(4, 6, -1, 0, 0);
        add_idle(5, 0);
        d0 = done_seen;
        compute_model();
        applyStimulus(tr_fv.size(), 1);
        check("ignored_done_count", done_seen - d0, 1);
        check("ignored_busy_after", busy, 0);
        check("ignored_count", lcount, STATS ? 6 : 0);

        // frame valid drops under a 3-pixel last line
        $display("[TB] truncated line");
        clear_trace();
        add_idle(2, 0); add_idle(1, 1); add_idle(3, 0);
        add_frame(4, 5, -1, 0, 3);
        add_idle(4, 0);
        compute_model();
        applyStimulus(tr_fv.size(), 1);
        check("trunc_count", lcount, STATS ? 4 : 0);
        check("trunc_width", lwidth, STATS ? 5 : 0);
        check("trunc_mismatch", mism, STATS ? 1 : 0);

        // randomized frames and request pulses
        $display("[TB] random segments");
        for (int seg = 0; seg < 8; seg++) begin
            clear_trace();
            add_idle(2, 0);
            nfr = $urandom_range(2, 4);
            for (int k = 0; k < nfr; k++) begin
                add_idle($urandom_range(1, 5), 0);
                lines = $urandom_range(1, 6);
                wid   = $urandom_range(2, 9);
                rag   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lines - 1) : -1;
                tr    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, wid) : 0;
                add_frame(lines, wid, rag, $urandom_range(1, 9), tr);
            end
            span = tr_fv.size();
            for (int p = 0; p < $urandom_range(1, 4); p++) begin
                set_start($urandom_range(0, span - 4), $urandom_range(1, 3));
            end
            add_idle(4, 0);
            add_frame(3, 4, -1, 0, 0);
            add_idle(4, 0);
            compute_model();
            applyStimulus(tr_fv.size(), 1);
        end

        // reset asserted on line 3 of a forwarded frame
        $display("[TB] reset mid-pass");
        clear_trace();
        add_idle(3, 0); add_idle(2, 1); add_idle(4, 0);
        add_frame(8, 6, -1, 0, 0);
        add_idle(4, 0);
        stop = line_starts[2] + 2;
        applyStimulus(stop, 0);
        check("prereset_fv", out_bus.frame_valid, 1);
        check("prereset_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset");
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
        held_w = 0; held_n = 0; held_m = 1'b0;
        clear_trace();
        add_idle(3, 0);
        add_frame(4, 5, -1, 0, 0);
        add_idle(4, 0);
        d0 = done_seen;
        compute_model();
        applyStimulus(tr_fv.size(), 1);
        check("postreset_done_count", done_seen - d0, 0);
        check("postreset_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
